tone_decoder: RTL
=================

// Module: tone_decoder
// PURPOSE
//  Receive-side partner to the key-driven buzzer tone generator. Measures the edge-to-edge
//  period of an external square wave (TONE_IN) and decodes it to one of the eight notes
//  do..do' (C5..C6), reported one-hot in the same bit order as the buzzer's KEY bus.
//  Used for loopback self-test of the buzzer path and for note recognition from external sources.
// PARAMETERS
//  CNT_W      17      width of the period counter and of the PERIOD output
//  TOL        1000    accept window in clk cycles: |period - nominal| <= TOL. Must be < 1420.
//  LOCK_CNT   3       consecutive matching periods of the same note needed to lock
//  TIMEOUT    120000  cycles without a rising edge before silence is declared; must be < 2^CNT_W
// PORTS
//  CLK_50M    in   1      50 MHz system clock
//  RST        in   1      asynchronous, active-high reset
//  TONE_IN    in   1      asynchronous square-wave input
//  NOTE       out  8      one-hot decoded note; 8'h00 = none
//  NOTE_VALID out  1      high while locked (NOTE != 0)
//  NOTE_CHG   out  1      1-cycle pulse whenever NOTE changes value
//  PERIOD     out  CNT_W  last measured rising-to-rising period, in clk cycles
// BEHAVIOUR
//  - Interface: one clock, CLK_50M. RST is asynchronous and active-high.
//  - Reset: all outputs are 0. Counter = 0, match count = 0, state = S_IDLE.
//    Reset asserted mid-measurement clears everything immediately; no partial result survives.
//  - Input path: TONE_IN -> 2-FF synchroniser -> rising-edge detect. The detect produces a
//    1-cycle pulse rise_p, 3 clk after the pin edge.
//  - Period counter: cleared to 1 on rise_p, otherwise incremented. It saturates at TIMEOUT.
//  - Nominal periods, indexed 0..7 (bit i of NOTE): 95550 85138 75840 71584 63778 56820
//    50620 47780. Each equals 2*(freq+1) of the buzzer divider.
//  - Classification (combinational, on counter value at rise_p): cand = index i whose window
//    contains the value; none if no window matches. Windows are disjoint for TOL<1420.
//    Compare in CNT_W+1 bits with no wrap.
//  - Register updates: all registered outputs change 1 clk after rise_p.
//    Pin-edge to NOTE latency = 4 clk.
//  - FSM:
//    S_IDLE : no edge since reset/timeout. rise_p -> S_MEAS. PERIOD is not updated on this
//             first edge; match = 0.
//    S_MEAS : on rise_p, PERIOD <= count.
//             If cand == prev cand and cand valid: match++, else match <= (cand valid ? 1 : 0).
//             When match reaches LOCK_CNT: NOTE <= 1<<cand, NOTE_VALID <= 1 -> S_LOCK.
//    S_LOCK : on rise_p, PERIOD <= count.
//             cand == locked note: stay.
//             Otherwise: NOTE <= 0, VALID <= 0 -> S_MEAS, match restarts as in S_MEAS.
//             A new note therefore needs LOCK_CNT fresh periods.
//    Any state except S_IDLE: counter reaches TIMEOUT with no rise_p -> NOTE <= 0,
//             VALID <= 0, match <= 0 -> S_IDLE. PERIOD holds its last value.
//  - Simultaneous rise_p and counter == TIMEOUT: the edge wins. It is classified normally and
//    the period never matches, since TIMEOUT exceeds every window.
//  - NOTE_CHG pulses in the cycle NOTE takes a new value: on lock, unlock and timeout.
// CONFIGURATION
//  TONE_DEGLITCH_EN defined:
//    - A 4-sample filter follows the synchroniser. The filtered level changes only after 4
//      consecutive equal samples; pulses of <= 3 clk are ignored.
//    - Pin-edge to NOTE latency becomes 8 clk. All periods are measured on the filtered signal.
//  TONE_DEGLITCH_EN undefined: the filter is absent, the synchroniser output feeds edge
//    detect directly, and latency is 4 clk.
// TESTING
//  1. Reset, then drive a square wave of period 95550 (50% duty).
//     -> After the 4th rising edge: NOTE=8'h01, NOTE_VALID=1, PERIOD=95550, one NOTE_CHG pulse.
//  2. Period 47780. -> NOTE=8'h80 after 4 edges. Switch to 56820.
//     -> Next edge: NOTE=0, VALID=0, NOTE_CHG. LOCK_CNT edges later: NOTE=8'h20.
//  3. Tolerance edges: period 76840 (75840+TOL) -> locks NOTE=8'h04.
//     Period 76841 -> NOTE stays 0; PERIOD=76841.
//  4. Locked on 8'h08, then hold TONE_IN low.
//     -> Exactly TIMEOUT clk after the last counter clear (+1 register cycle): NOTE=0,
//        VALID=0, NOTE_CHG pulse. Back to S_IDLE; the next first edge leaves PERIOD unchanged.
//  5. Assert RST for 1 clk mid-lock.
//     -> NOTE, NOTE_VALID, NOTE_CHG and PERIOD are all 0 in the same cycle; relock needs
//        1+LOCK_CNT edges.
//  6. TONE_DEGLITCH_EN: inject 2-clk glitch pulses into an 8'h10 tone.
//     -> Lock is held and PERIOD stays 63778. Without the macro the lock drops.

Source files
------------

// File: rtl/tone_decoder.sv
// tone_decoder: measures the rising-to-rising period of TONE_IN and decodes it to one of eight notes.
// Define TONE_DEGLITCH_EN to insert a 4-sample level filter after the synchroniser.
module tone_decoder #(
  parameter int CNT_W    = 17,
  parameter int TOL      = 1000,
  parameter int LOCK_CNT = 3,
  parameter int TIMEOUT  = 120000,
  parameter int NOM_DIV  = 1
) (
  input  logic             clk_50m_i,
  input  logic             rst_i,
  input  logic             tone_in_i,
  output logic [7:0]       note_o,
  output logic             note_valid_o,
  output logic             note_chg_o,
  output logic [CNT_W-1:0] period_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  typedef logic [CNT_W:0] wide_t;
  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_LOCK} state_t;

  // NOM_DIV scales the whole note table down uniformly; 1 gives the real C5..C6 periods.
  function automatic wide_t nominal(input int idx);
    case (idx)
      0:       return wide_t'(95550 / NOM_DIV);
      1:       return wide_t'(85138 / NOM_DIV);
      2:       return wide_t'(75840 / NOM_DIV);
      3:       return wide_t'(71584 / NOM_DIV);
      4:       return wide_t'(63778 / NOM_DIV);
      5:       return wide_t'(56820 / NOM_DIV);
      6:       return wide_t'(50620 / NOM_DIV);
      default: return wide_t'(47780 / NOM_DIV);
    endcase
  endfunction

  logic sync1_q, sync2_q, lvl, lvl_prev_q, rise_q;

  always_ff @(posedge clk_50m_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tone_in_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef TONE_DEGLITCH_EN
  logic [2:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk_50m_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], sync2_q};
      if (hist_q == {3{sync2_q}}) filt_q <= sync2_q;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk_50m_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_prev_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      rise_q     <= lvl & ~lvl_prev_q;
    end
  end

  logic [CNT_W-1:0] cnt_q;
  logic             cand_vld;
  logic [2:0]       cand_idx;
  logic [7:0]       cand_oh;
  wide_t            cnt_w, nom, diff;

  // One extra bit so |cnt - nom| never wraps.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    cnt_w    = {1'b0, cnt_q};
    nom      = '0;
    diff     = '0;
    for (int i = 0; i < 8; i++) begin
      nom  = nominal(i);
      diff = (cnt_w >= nom) ? (cnt_w - nom) : (nom - cnt_w);
      if (diff <= wide_t'(TOL)) begin
        cand_vld = 1'b1;
        cand_idx = 3'(i);
      end
    end
  end

  assign cand_oh = 8'b1 << cand_idx;

  state_t           state_q;
  logic [MW-1:0]    match_q, match_d;
  logic             prev_vld_q;
  logic [2:0]       prev_idx_q;
  logic [7:0]       note_q;
  logic             valid_q, chg_q;
  logic [CNT_W-1:0] period_q;
  logic             same_cand, timeout;

  assign same_cand = cand_vld && prev_vld_q && (cand_idx == prev_idx_q);
  assign match_d   = same_cand ? match_q + 1'b1 : MW'(cand_vld);
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT)) && !rise_q;

  always_ff @(posedge clk_50m_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      match_q    <= '0;
      prev_vld_q <= 1'b0;
      prev_idx_q <= '0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      chg_q      <= 1'b0;
      period_q   <= '0;
    end else begin
      chg_q <= 1'b0;
      if (rise_q)                           cnt_q <= CNT_W'(1);
      else if (cnt_q != CNT_W'(TIMEOUT))    cnt_q <= cnt_q + 1'b1;

      if (rise_q && state_q != S_IDLE) begin
        period_q   <= cnt_q;
        prev_vld_q <= cand_vld;
        prev_idx_q <= cand_idx;
      end

      case (state_q)
        S_IDLE: begin
          if (rise_q) begin
            state_q    <= S_MEAS;
            match_q    <= '0;
            prev_vld_q <= 1'b0;
          end
        end
        S_MEAS: begin
          if (rise_q) begin
            match_q <= match_d;
            if (match_d == MW'(LOCK_CNT)) begin
              note_q  <= cand_oh;
              valid_q <= 1'b1;
              chg_q   <= 1'b1;
              state_q <= S_LOCK;
            end
          end else if (timeout) begin
            match_q    <= '0;
            prev_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_LOCK: begin
          if (rise_q) begin
            // prev_idx_q holds the locked note while in this state
            if (!(cand_vld && cand_idx == prev_idx_q)) begin
              note_q  <= '0;
              valid_q <= 1'b0;
              chg_q   <= 1'b1;
              match_q <= match_d;
              state_q <= S_MEAS;
            end
          end else if (timeout) begin
            note_q     <= '0;
            valid_q    <= 1'b0;
            chg_q      <= 1'b1;
            match_q    <= '0;
            prev_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign note_o       = note_q;
  assign note_valid_o = valid_q;
  assign note_chg_o   = chg_q;
  assign period_o     = period_q;

endmodule
